// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request in flight and
// hands {instr, instr_pc} to decode over valid/ready; execute may redirect the PC at any time.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    logic [31:0] pc;
    logic        drop;
    logic        redirect_ok;
    logic        redirect_bad;
    logic        accept;

    assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // A request only counts as accepted when it was actually presented to memory.
    assign accept       = imem_req && imem_ready;
    assign imem_addr    = pc;

    // Fetch FSM; imem_req and instr_valid are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr       <= NOP;
            instr_pc    <= 32'h0000_0000;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
        end else if (redirect_bad) begin
            state       <= S_ERR;
            fetch_err   <= 1'b1;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_ok) begin
                        pc <= redirect_pc;
                    end
                    if (accept) begin
                        // The accepted address is stale if a redirect lands in the same cycle.
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                        drop     <= redirect_ok;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect_ok) begin
                        pc <= redirect_pc;
                    end
                    if (imem_rvalid) begin
                        if (drop || redirect_ok) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                            drop     <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            state       <= S_HOLD;
                            instr_valid <= 1'b1;
                        end
                    end else if (redirect_ok) begin
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect wins over the sequential step even when decode consumes.
                    if (redirect_ok || instr_ready) begin
                        pc          <= redirect_ok ? redirect_pc : (pc + PC_STEP);
                        state       <= S_REQ;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state       <= S_ERR;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
